// File: rtl/decode_layer_scheduler_pkg.sv
// Shared decoder constants: layer/iteration defaults and scheduler state encoding.
// MAX_ITER comes from the decoder-wide macro so every block agrees on it.
`ifndef MAX_ITER
`define MAX_ITER 10
`endif

package decode_layer_scheduler_pkg;

  localparam int LAYER_NUM_DEF = 3;
  localparam int MAX_ITER_DEF  = `MAX_ITER;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE      = 3'd0;
  localparam sched_state_t ST_START     = 3'd1;
  localparam sched_state_t ST_LAYER_RUN = 3'd2;
  localparam sched_state_t ST_SYN_WAIT  = 3'd3;
  localparam sched_state_t ST_NEXT      = 3'd4;
  localparam sched_state_t ST_TERM      = 3'd5;

endpackage

// File: rtl/layer_iter_counter.sv
// Layer and iteration counters for the decode scheduler.
// Both counters saturate at their last value; clear has priority over increment.
module layer_iter_counter #(
  parameter int LAYER_NUM = 3,
  parameter int MAX_ITER  = 10,
  parameter int LW        = $clog2(LAYER_NUM),
  parameter int IW        = $clog2(MAX_ITER + 1)
) (
  input  logic          read_clk,
  input  logic          rstn,
  input  logic          layer_inc,
  input  logic          layer_clear,
  input  logic          iter_inc,
  input  logic          iter_clear,
  output logic [LW-1:0] layer_idx,
  output logic [IW-1:0] iter_idx,
  output logic          layer_last,
  output logic          iter_last
);

  localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_NUM - 1);
  localparam logic [IW-1:0] ITER_LAST  = IW'(MAX_ITER - 1);

  assign layer_last = (layer_idx == LAYER_LAST);
  assign iter_last  = (iter_idx == ITER_LAST);

  // Layer counter: steps through the layers of one iteration, never past the last one
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      layer_idx <= '0;
    end else if (layer_clear) begin
      layer_idx <= '0;
    end else if (layer_inc && !layer_last) begin
      layer_idx <= layer_idx + 1'b1;
    end
  end

  // Iteration counter: 0-based, holds at the final iteration instead of wrapping
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      iter_idx <= '0;
    end else if (iter_clear) begin
      iter_idx <= '0;
    end else if (iter_inc && !iter_last) begin
      iter_idx <= iter_idx + 1'b1;
    end
  end

endmodule

// File: rtl/decode_layer_scheduler.sv
// Layered-decoder scheduler: sequences layers and iterations for one frame,
// tracks the outstanding VNU update, and decides when decoding terminates.
module decode_layer_scheduler
  import decode_layer_scheduler_pkg::*;
#(
  parameter int LAYER_NUM = LAYER_NUM_DEF,
  parameter int MAX_ITER  = MAX_ITER_DEF,
  parameter int LW        = $clog2(LAYER_NUM),
  parameter int IW        = $clog2(MAX_ITER + 1)
) (
  input  logic          read_clk,
  input  logic          rstn,
  input  logic          frame_valid,
  output logic          frame_ack,
  input  logic          decode_abort,
  input  logic          c2v_wb_done,
  input  logic          vnu_wb_done,
  input  logic          syndrome_valid,
  input  logic          syndrome_zero,
  output logic          fsm_en,
  output logic          layer_finish,
  output logic          vnu_update_pend,
  output logic          termination,
  output logic [LW-1:0] layer_idx,
  output logic [IW-1:0] iter_idx,
  output logic          decode_done,
  output logic          decode_success
);

  sched_state_t state;
  sched_state_t state_nxt;

  logic success_q;
  logic layer_last;
  logic iter_last;

  logic accept;
  logic abort;
  logic c2v_run;
  logic syn_hit;
  logic syn_term;
  logic syn_next;

  logic layer_inc;
  logic layer_clear;
  logic iter_inc;
  logic iter_clear;

  // Abort outranks every other event; a frame is only taken while idle.
  assign accept   = (state == ST_IDLE) && frame_valid;
  assign abort    = (state != ST_IDLE) && decode_abort;
  assign c2v_run  = (state == ST_LAYER_RUN) && c2v_wb_done && !abort;
  assign syn_hit  = (state == ST_SYN_WAIT) && !vnu_update_pend && syndrome_valid && !abort;
  assign syn_term = syn_hit && (syndrome_zero || iter_last);
  assign syn_next = syn_hit && !(syndrome_zero || iter_last);

  assign layer_inc   = c2v_run && !layer_last;
  assign layer_clear = accept || ((state == ST_NEXT) && !abort);
  assign iter_inc    = (state == ST_NEXT) && !abort;
  assign iter_clear  = accept;

  layer_iter_counter #(
    .LAYER_NUM (LAYER_NUM),
    .MAX_ITER  (MAX_ITER),
    .LW        (LW),
    .IW        (IW)
  ) u_counter (
    .read_clk    (read_clk),
    .rstn        (rstn),
    .layer_inc   (layer_inc),
    .layer_clear (layer_clear),
    .iter_inc    (iter_inc),
    .iter_clear  (iter_clear),
    .layer_idx   (layer_idx),
    .iter_idx    (iter_idx),
    .layer_last  (layer_last),
    .iter_last   (iter_last)
  );

  // Next-state decision; TERM always returns to IDLE so one frame yields one termination
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (frame_valid) state_nxt = ST_START;
      ST_START:     state_nxt = abort ? ST_TERM : ST_LAYER_RUN;
      ST_LAYER_RUN: begin
        if (abort)                       state_nxt = ST_TERM;
        else if (c2v_run && layer_last)  state_nxt = ST_SYN_WAIT;
      end
      ST_SYN_WAIT: begin
        if (abort)         state_nxt = ST_TERM;
        else if (syn_term) state_nxt = ST_TERM;
        else if (syn_next) state_nxt = ST_NEXT;
      end
      ST_NEXT:      state_nxt = abort ? ST_TERM : ST_LAYER_RUN;
      ST_TERM:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Registered one-cycle pulses: frame acceptance and layer handover to the CNU control
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      frame_ack    <= 1'b0;
      layer_finish <= 1'b0;
    end else begin
      frame_ack    <= accept;
      layer_finish <= layer_inc || syn_next;
    end
  end

  // Outstanding VNU update: a new C2V write-back wins over a same-cycle VNU completion
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      vnu_update_pend <= 1'b0;
    end else if (state == ST_TERM) begin
      vnu_update_pend <= 1'b0;
    end else if (c2v_run) begin
      vnu_update_pend <= 1'b1;
    end else if (vnu_wb_done) begin
      vnu_update_pend <= 1'b0;
    end
  end

  // Latched syndrome outcome reported at termination; an abort forces failure
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      success_q <= 1'b0;
    end else if (accept || abort) begin
      success_q <= 1'b0;
    end else if (syn_hit) begin
      success_q <= syndrome_zero;
    end
  end

  assign fsm_en         = (state != ST_IDLE);
  assign termination    = (state == ST_TERM);
  assign decode_done    = termination;
  assign decode_success = termination && success_q;

endmodule

// File: tb/tb_decode_layer_scheduler.sv
// Directed bench for decode_layer_scheduler with LAYER_NUM=3, MAX_ITER=10.
module tb_decode_layer_scheduler;

  localparam int LAYER_NUM = 3;
  localparam int MAX_ITER  = 10;
  localparam int LW        = $clog2(LAYER_NUM);
  localparam int IW        = $clog2(MAX_ITER + 1);

  logic          read_clk = 1'b0;
  logic          rstn;
  logic          frame_valid;
  logic          frame_ack;
  logic          decode_abort;
  logic          c2v_wb_done;
  logic          vnu_wb_done;
  logic          syndrome_valid;
  logic          syndrome_zero;
  logic          fsm_en;
  logic          layer_finish;
  logic          vnu_update_pend;
  logic          termination;
  logic [LW-1:0] layer_idx;
  logic [IW-1:0] iter_idx;
  logic          decode_done;
  logic          decode_success;

  int checks = 0;
  int errors = 0;
  int lf_total = 0;
  int lf_start = 0;

  decode_layer_scheduler #(
    .LAYER_NUM (LAYER_NUM),
    .MAX_ITER  (MAX_ITER)
  ) dut (
    .read_clk        (read_clk),
    .rstn            (rstn),
    .frame_valid     (frame_valid),
    .frame_ack       (frame_ack),
    .decode_abort    (decode_abort),
    .c2v_wb_done     (c2v_wb_done),
    .vnu_wb_done     (vnu_wb_done),
    .syndrome_valid  (syndrome_valid),
    .syndrome_zero   (syndrome_zero),
    .fsm_en          (fsm_en),
    .layer_finish    (layer_finish),
    .vnu_update_pend (vnu_update_pend),
    .termination     (termination),
    .layer_idx       (layer_idx),
    .iter_idx        (iter_idx),
    .decode_done     (decode_done),
    .decode_success  (decode_success)
  );

  // Free-running decoder clock
  always #5 read_clk = ~read_clk;

  // Count layer_finish pulses mid-cycle
  always @(negedge read_clk) if (layer_finish === 1'b1) lf_total++;

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle
  task automatic applyStimulus(input logic fv, input logic c2v, input logic vnu,
                               input logic sv, input logic sz, input logic ab);
    frame_valid    = fv;
    c2v_wb_done    = c2v;
    vnu_wb_done    = vnu;
    syndrome_valid = sv;
    syndrome_zero  = sz;
    decode_abort   = ab;
    @(posedge read_clk);
    #1;
    frame_valid    = 1'b0;
    c2v_wb_done    = 1'b0;
    vnu_wb_done    = 1'b0;
    syndrome_valid = 1'b0;
    syndrome_zero  = 1'b0;
    decode_abort   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstn           = 1'b0;
    frame_valid    = 1'b0;
    decode_abort   = 1'b0;
    c2v_wb_done    = 1'b0;
    vnu_wb_done    = 1'b0;
    syndrome_valid = 1'b0;
    syndrome_zero  = 1'b0;

    // Reset state
    repeat (3) @(posedge read_clk);
    #1;
    checkOutput("rst_fsm_en", fsm_en, 0);
    checkOutput("rst_frame_ack", frame_ack, 0);
    checkOutput("rst_layer_idx", layer_idx, 0);
    checkOutput("rst_iter_idx", iter_idx, 0);
    checkOutput("rst_term", termination, 0);
    checkOutput("rst_pend", vnu_update_pend, 0);
    checkOutput("rst_lf", layer_finish, 0);
    rstn = 1'b1;

    // Scenario 1: single iteration, syndrome zero
    $display("[TB] scenario 1: one iteration, syndrome zero");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("s1_frame_ack", frame_ack, 1);
    checkOutput("s1_fsm_en", fsm_en, 1);
    checkOutput("s1_start_layer", layer_idx, 0);
    checkOutput("s1_start_iter", iter_idx, 0);
    lf_start = lf_total;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s1_ack_pulse", frame_ack, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("s1_layer1", layer_idx, 1);
    checkOutput("s1_lf1", layer_finish, 1);
    checkOutput("s1_pend_set", vnu_update_pend, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("s1_layer2", layer_idx, 2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("s1_last_no_lf", layer_finish, 0);
    checkOutput("s1_no_term_yet", termination, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("s1_pend_clr", vnu_update_pend, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("s1_term", termination, 1);
    checkOutput("s1_done", decode_done, 1);
    checkOutput("s1_success", decode_success, 1);
    checkOutput("s1_iter", iter_idx, 0);
    checkOutput("s1_lf_count", lf_total - lf_start, 2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s1_idle_en", fsm_en, 0);
    checkOutput("s1_term_pulse", termination, 0);

    // Scenario 2: syndrome never zero, run to the iteration limit
    $display("[TB] scenario 2: iteration limit");
    applyStimulus(1, 0, 0, 0, 0, 0);
    lf_start = lf_total;
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int it = 0; it < MAX_ITER; it++) begin
      repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      if (it < MAX_ITER - 1) begin
        checkOutput("s2_next_lf", layer_finish, 1);
        checkOutput("s2_next_noterm", termination, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("s2_iter_inc", iter_idx, it + 1);
        checkOutput("s2_layer_zero", layer_idx, 0);
      end else begin
        checkOutput("s2_term", termination, 1);
        checkOutput("s2_success", decode_success, 0);
        checkOutput("s2_iter_last", iter_idx, 9);
      end
    end
    checkOutput("s2_lf_count", lf_total - lf_start, 29);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s2_idle_en", fsm_en, 0);

    // Scenarios 3/4: simultaneous set/clear of pend, syndrome ignored while pending
    $display("[TB] scenario 3/4: pending flag handling");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("s3_set_wins", vnu_update_pend, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("s3_later_clr", vnu_update_pend, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("s4_pend_syn_wait", vnu_update_pend, 1);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("s4_syn_ignored", termination, 0);
    checkOutput("s4_still_en", fsm_en, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("s4_pend_clr", vnu_update_pend, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("s4_term", termination, 1);
    checkOutput("s4_success", decode_success, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Scenario 5: abort in layer 1 of iteration 4, abort beats a same-cycle c2v
    $display("[TB] scenario 5: abort");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int it = 0; it < 4; it++) begin
      repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("s5_layer_pre", layer_idx, 1);
    checkOutput("s5_iter_pre", iter_idx, 4);
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("s5_term", termination, 1);
    checkOutput("s5_done", decode_done, 1);
    checkOutput("s5_success", decode_success, 0);
    checkOutput("s5_layer_hold", layer_idx, 1);
    checkOutput("s5_no_ack", frame_ack, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s5_idle_en", fsm_en, 0);
    checkOutput("s5_term_pulse", termination, 0);

    // Scenario 6: asynchronous reset mid-layer
    $display("[TB] scenario 6: reset mid-frame");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("s6_pre_layer", layer_idx, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("s6_rst_en", fsm_en, 0);
    checkOutput("s6_rst_layer", layer_idx, 0);
    checkOutput("s6_rst_lf", layer_finish, 0);
    checkOutput("s6_rst_pend", vnu_update_pend, 0);
    checkOutput("s6_rst_term", termination, 0);
    @(posedge read_clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("s6_ack", frame_ack, 1);
    checkOutput("s6_layer", layer_idx, 0);
    checkOutput("s6_en", fsm_en, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_layer_scheduler.md
DECODE_LAYER_SCHEDULER -- requirements
Module: decode_layer_scheduler

Interface
REQ-001 Parameters, one per line:
- LAYER_NUM, 3, layers per iteration.
- MAX_ITER, `MAX_ITER, maximum iterations per frame.
- LW = $clog2(LAYER_NUM); IW = $clog2(MAX_ITER+1).

REQ-002 Ports, one per line:
- read_clk  in  1  decoder clock.
- rstn  in  1  reset: asynchronous, active-low; clock read_clk.
- frame_valid  in  1  new channel frame loaded, level.
- frame_ack  out  1  one-cycle pulse, frame accepted.
- decode_abort  in  1  host abort, pulse.
- c2v_wb_done  in  1  pulse, CNU C2V memory write of the current layer done.
- vnu_wb_done  in  1  pulse, VNU IB-RAM update done.
- syndrome_valid  in  1  pulse, parity check result available.
- syndrome_zero  in  1  qualified by syndrome_valid.
- fsm_en  out  1  enables the CNU control unit.
- layer_finish  out  1  one-cycle pulse to the CNU control unit.
- vnu_update_pend  out  1  level, VNU update outstanding.
- termination  out  1  one-cycle pulse, frame decoding ended.
- layer_idx  out  LW  current layer.
- iter_idx  out  IW  current iteration, 0-based.
- decode_done  out  1  one-cycle pulse, coincident with termination.
- decode_success  out  1  valid with decode_done: syndrome was zero.

Function
REQ-010 States: IDLE, START, LAYER_RUN, SYN_WAIT, NEXT, TERM.
REQ-011 In IDLE, fsm_en=0. frame_valid=1 moves the FSM to START and raises frame_ack in that same transition cycle.
REQ-012 In START, layer_idx=0 and iter_idx=0, and fsm_en rises. The FSM moves to LAYER_RUN after 1 cycle.
REQ-013 fsm_en=1 in every state except IDLE.
REQ-014 LAYER_RUN, c2v_wb_done with layer_idx<LAYER_NUM-1: layer_finish pulses in the next cycle, layer_idx increments, and the FSM stays in LAYER_RUN.
REQ-015 LAYER_RUN, c2v_wb_done with layer_idx=LAYER_NUM-1: the FSM moves to SYN_WAIT and layer_finish is not pulsed.
REQ-016 SYN_WAIT ignores syndrome_valid while vnu_update_pend=1. Once pend=0 and syndrome_valid=1:
- If syndrome_zero=1 or iter_idx=MAX_ITER-1, the FSM moves to TERM.
- Otherwise it moves to NEXT.
REQ-017 NEXT: layer_finish pulses, layer_idx returns to 0, iter_idx increments, and the FSM moves to LAYER_RUN. This is 1 cycle.
REQ-018 TERM: termination, decode_done and decode_success (= latched syndrome_zero) are valid for 1 cycle, then the FSM moves to IDLE.
REQ-019 vnu_update_pend sets on c2v_wb_done and clears on vnu_wb_done. If both occur in the same cycle, the set wins. vnu_wb_done while pend=0 is ignored.
REQ-020 c2v_wb_done outside LAYER_RUN is ignored. syndrome_valid outside SYN_WAIT is ignored.
REQ-021 frame_valid while not IDLE is ignored, with no frame_ack.
REQ-022 decode_abort in any non-IDLE state forces TERM next cycle with decode_success=0. decode_abort takes priority over every other event in the same cycle.
REQ-023 Counters never wrap: iter_idx ≤ MAX_ITER-1 and layer_idx ≤ LAYER_NUM-1.

Reset
REQ-030 Asserting rstn puts the FSM in IDLE and clears every output and counter to 0, including mid-frame. No termination pulse is produced on reset.
REQ-031 After rstn deasserts, the first frame_valid is accepted on the following clock edge.

Structure
REQ-040 The state encoding, LAYER_NUM and MAX_ITER belong in the shared decoder package/define.vh. `MAX_ITER is reused.
REQ-041 One sub-module, layer_iter_counter, holds layer_idx/iter_idx with inc/clear/last flags. The FSM and pend flag are inline.

Verification
REQ-050 Bench scenarios (LAYER_NUM=3, MAX_ITER=10):
- frame_valid=1, c2v_wb_done ×3, vnu_wb_done, syndrome_valid with zero=1 -> layer_finish ×2, termination after 1 iteration, decode_success=1, iter_idx=0.
- syndrome_zero=0 always -> 10 iterations, 29 layer_finish pulses, termination with decode_success=0, iter_idx=9.
- c2v_wb_done and vnu_wb_done in the same cycle -> vnu_update_pend stays 1. A later vnu_wb_done clears it.
- syndrome_valid while pend=1 -> ignored. A second syndrome_valid after vnu_wb_done -> acted on.
- decode_abort in layer 1 of iteration 4 -> TERM next cycle, decode_success=0, then IDLE with fsm_en=0.
- rstn low mid-LAYER_RUN -> all outputs 0 immediately. The next frame_valid yields frame_ack with layer_idx=0.
